// File: rtl/calc_pkg.sv
// Shared calculator datapath constants and the converter state encoding.
// Used by the arithmetic unit, the BCD converter and the display driver.
package calc_pkg;

    localparam int CALC_WIDTH = 14;
    localparam int CALC_MAX   = 9999;
    localparam int BCD_DIGITS = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake and result bus between the arithmetic unit (master)
// and the sequential binary-to-BCD converter (slave).
interface bin_to_bcd_seq_if
    import calc_pkg::*;
#(
    parameter int WIDTH  = CALC_WIDTH,
    parameter int DIGITS = BCD_DIGITS
);

    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [DIGITS-1:0]     blank;
    logic                  overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, blank, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, blank, overflow
    );

endinterface

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit corrector: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: clamps to the display limit, then runs
// one double-dabble iteration per clock and reports digits plus blank mask.
module bin_to_bcd_seq
    import calc_pkg::*;
#(
    parameter int WIDTH   = CALC_WIDTH,
    parameter int DIGITS  = BCD_DIGITS,
    parameter int MAX_VAL = CALC_MAX
) (
    input  logic             clk,
    input  logic             rst,
    bin_to_bcd_seq_if.slave  bus
);

    localparam int                ACC_W     = 4 * DIGITS;
    localparam int                CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0]  MAX_W     = WIDTH'(MAX_VAL);
    localparam logic [CNT_W-1:0]  CNT_TOP   = CNT_W'(WIDTH - 1);
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    opnd_q, opnd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                clamp_q, clamp_d;
    logic [ACC_W-1:0]    bcd_q, bcd_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;

    logic [ACC_W-1:0]    acc_corr;
    logic [ACC_W-1:0]    acc_shift;
    logic [DIGITS-1:0]   blank_calc;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .din  (acc_q[4*g +: 4]),
            .dout (acc_corr[4*g +: 4])
        );
    end

    // Correct every digit first, then shift the operand MSB into the accumulator.
    assign acc_shift = {acc_corr[ACC_W-2:0], opnd_q[WIDTH-1]};

    always_comb begin : blank_scan
        logic zero_above;
        zero_above = 1'b1;
        blank_calc = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above    = zero_above & (acc_shift[4*i +: 4] == 4'd0);
            blank_calc[i] = zero_above;
        end
        blank_calc[0] = 1'b0;
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        clamp_d = clamp_q;
        bcd_d   = bcd_q;
        blank_d = blank_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = CNT_TOP;
                    acc_d   = '0;
                    clamp_d = (bus.bin_in > MAX_W);
                    opnd_d  = (bus.bin_in > MAX_W) ? MAX_W : bus.bin_in;
                end
            end
            ST_SHIFT: begin
                acc_d  = acc_shift;
                opnd_d = {opnd_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    bcd_d   = acc_shift;
                    blank_d = blank_calc;
                    ovf_d   = clamp_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values; the shift register is small and is cleared
    // on reset along with the control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            clamp_q <= 1'b0;
            bcd_q   <= '0;
            blank_q <= BLANK_RST;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            clamp_q <= clamp_d;
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = (state_q == ST_SHIFT);
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.blank    = blank_q;
    assign bus.overflow = ovf_q;

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter for the calculator datapath.
- Takes the 14-bit binary result produced by the arithmetic unit.
- Converts it with the shift-and-add-3 (double-dabble) method, one bit per clock.
- Presents four packed BCD digits plus a leading-zero blank mask to the 7-segment display driver.
- Start/done handshake; clamps out-of-range inputs to the calculator display limit.

Parameters:
- WIDTH, 14, binary input width.
- DIGITS, 4, number of BCD output digits.
- MAX_VAL, 9999, largest displayable value; inputs above it are clamped.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  request conversion of bin_in; sampled only when busy=0
- bin_in  input  WIDTH  unsigned binary value to convert
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse; bcd_out/blank/overflow valid and updated
- bcd_out  output  4*DIGITS  packed BCD, digit 3 (thousands) in [15:12], digit 0 in [3:0]
- blank  output  DIGITS  1 = digit is a leading zero, to be blanked; digit 0 never blanked
- overflow  output  1  last converted input exceeded MAX_VAL and was clamped

Behaviour:
- Reset values, held while rst=1:
  - state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, blank=4'b1110.
  - Shift register and bit counter are cleared.
- States are IDLE and SHIFT; busy = (state==SHIFT).
- IDLE:
  - If start=1 at a clock edge, latch the operand and go to SHIFT with bit counter = WIDTH-1.
  - The latched operand is bin_in, or MAX_VAL if bin_in > MAX_VAL.
  - The clamp flag is latched at the same edge into an internal register.
- SHIFT, one iteration per clock:
  - Each 4-bit digit of the BCD accumulator that is >= 5 gets 3 added.
  - Then {accumulator, operand} shifts left by 1.
  - The counter decrements.
- On the iteration with counter == 0:
  - Register the final accumulator into bcd_out.
  - Compute blank from the final digits, scanning from MSD down. A digit is blanked if it and all higher digits are 0. Digit 0 is forced unblanked.
  - Copy the clamp flag to overflow.
  - Pulse done=1 for exactly one cycle and return to IDLE.
- Latency: start sampled at edge k; done=1 during the cycle after edge k+WIDTH (14 edges later, with default WIDTH).
- Output hold: bcd_out, blank and overflow hold their values between done pulses and change only on done.
- Input stability: bin_in is not required to stay stable after the start edge.
- start while busy=1: ignored; there is no queueing.
- Back-to-back: in the done cycle busy=0, so a start there is accepted; the next conversion begins with no bubble.
- Reset mid-conversion: the conversion is abandoned, no done pulse is produced, and all outputs return to reset values.
- Arithmetic:
  - The accumulator is 4*DIGITS bits.
  - The add-3 correction is applied per digit before each shift.
  - Because of the clamp, the result is never above 9999 and no digit exceeds 9.

Decomposition:
- Shared package calc_pkg:
  - CALC_WIDTH=14, CALC_MAX=9999, BCD_DIGITS=4 (shared with the arithmetic unit and display driver).
  - State encoding constants ST_IDLE, ST_SHIFT.
- One natural sub-module: bcd_add3, a 4-bit combinational digit corrector (out = in>=5 ? in+3 : in). It is instantiated DIGITS times with a generate loop.

Test Plan:
- Basic conversion with exact latency:
  - Stimulus: rst 2 cycles, then start with bin_in=1234.
  - Required: done exactly 14 edges after start; bcd_out=16'h1234, blank=4'b0000, overflow=0; busy high for 14 cycles.
- Zero and single digit:
  - bin_in=0 → bcd_out=16'h0000, blank=4'b1110.
  - bin_in=7 → bcd_out=16'h0007, blank=4'b1110.
  - bin_in=45 → bcd_out=16'h0045, blank=4'b1100.
- Boundary and clamp:
  - bin_in=9999 → bcd_out=16'h9999, overflow=0.
  - bin_in=10000 → 16'h9999, overflow=1.
  - bin_in=16383 → 16'h9999, overflow=1.
  - A following bin_in=5 → overflow returns to 0.
- Busy handling and back-to-back:
  - Start 1234, then pulse start with 4321 at cycle 5 → ignored; only 1234 is reported.
  - Start 4321 in the done cycle → second done 14 edges later with 16'h4321, no idle gap.
- Reset mid-operation:
  - Start 8765; assert rst at cycle 7 for 1 cycle.
  - Required: no done pulse; bcd_out=0, busy=0, blank=4'b1110.
  - A new start 8765 then completes normally with 16'h8765.
- Exhaustive sweep: every value 0..16383, each compared against a reference model of digit extraction plus clamp; every conversion must take exactly 14 cycles.
